instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Consumer side of the program counter: turns a running fetch address into instruction-memory read requests and returns the instructions, tagged with their addresses, to the decode stage.
- Owns its own word-addressed fetch PC, which advances by 1 per accepted request.
- Issues requests over a valid/ready interface and accepts in-order responses of variable latency.
- Buffers results in a QDEPTH-entry FIFO.
- Supports branch redirect with flush of queued and in-flight fetches.

Parameters:
ADDR_W, 32, width of fetch address / PC
DATA_W, 32, instruction width
QDEPTH, 4, instruction FIFO depth and maximum in-flight requests; power of 2, at least 2
RESET_PC, 0, fetch address loaded on reset

Ports:
clock  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-low reset; state cleared on posedge clock while reset==0
redirect_valid  in  1  one-cycle branch redirect request
redirect_pc  in  ADDR_W  new fetch address, sampled when redirect_valid==1
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  request word address (= fetch_pc)
mem_rsp_valid  in  1  read data valid; responses arrive in request order; unit always accepts
mem_rsp_data  in  DATA_W  read data
inst_valid  out  1  FIFO head valid (FIFO non-empty)
inst_ready  in  1  decode accepts head
inst_data  out  DATA_W  head instruction
inst_pc  out  ADDR_W  address of head instruction
fetch_pc  out  ADDR_W  next address to request

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC; rsp_pc=RESET_PC.
  - FIFO empty; live=0, drop=0.
  - Outputs: inst_valid=0, mem_req_valid=0, inst_data=0, inst_pc=0.
  - mem_rsp_valid is ignored while reset==0. The memory shares this reset and discards its in-flight reads, so a mid-operation reset loses everything with no stale data delivered.
- Counters (width clog2(QDEPTH)+1):
  - live: in-flight requests whose data will be kept.
  - drop: in-flight requests whose data will be discarded.
  - count: FIFO occupancy.
- Request issue (combinational):
  - mem_req_valid = reset && !redirect_valid && (live+drop+count < QDEPTH).
  - mem_req_addr = fetch_pc.
  - Handshake = mem_req_valid && mem_req_ready; on handshake: fetch_pc += 1 (mod 2^ADDR_W, wraps to 0), live += 1.
  - The credit rule guarantees every kept response has a free FIFO slot; no overflow is possible.
- Response handling, mem_rsp_valid==1 with no redirect in the same cycle:
  - If drop>0: drop -= 1, data discarded.
  - Else: push {rsp_pc, mem_rsp_data}, rsp_pc += 1 (wraps), live -= 1.
  - drop has priority: kept data only follows all discarded data.
- Output: inst_valid = (count != 0); head is registered FIFO storage. Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle allowed at any occupancy including full; count unchanged.
  - Minimum latency: response at cycle N -> inst_valid at cycle N+1.
  - Request accepted at cycle N with 1-cycle memory -> inst_valid at N+2.
- Redirect (redirect_valid==1 at posedge, reset==1), which overrides all same-cycle updates:
  - fetch_pc=redirect_pc; rsp_pc=redirect_pc; FIFO flushed (count=0; same-cycle pop irrelevant).
  - drop = drop + live - (mem_rsp_valid ? 1 : 0); live = 0. A same-cycle response is discarded. No request handshakes occur in a redirect cycle, since mem_req_valid is forced to 0.
  - inst_valid=0 the cycle after redirect.
  - Back-to-back redirects accumulate drop correctly; drop never exceeds QDEPTH.
- Boundaries:
  - count==QDEPTH with inst_ready==0: mem_req_valid=0, no stall on the response side (no credit was granted).
  - mem_req_ready==0: mem_req_addr and fetch_pc hold.
  - fetch_pc = 2^ADDR_W-1 accepted -> next fetch_pc=0, and inst_pc sequence wraps identically.
- Flag as assertion errors:
  - mem_rsp_valid when live+drop==0.
  - count>QDEPTH.

Test Plan:
- Reset then stream: reset=0 for 2 cycles, reset=1, mem_req_ready=1, 1-cycle memory returning data=addr+0x100, inst_ready=1 -> fetch addresses 0,1,2,...; inst_pc 0,1,2 with inst_data 0x100,0x101,0x102; first inst_valid 2 cycles after the first handshake.
- Backpressure/full: QDEPTH=4, inst_ready=0 -> exactly 4 handshakes (addr 0-3), then mem_req_valid=0. Raise inst_ready -> pops 0..3 in order, requests resume at addr 4.
- Redirect with in-flight: 3-cycle memory; issue addr 0,1,2, redirect_pc=0x40 while all 3 are outstanding (one response arriving that cycle) -> no data from 0-2 reaches inst; next request addr 0x40; first inst_pc=0x40.
- Back-to-back redirects: redirect to 0x10 then 0x20 on consecutive cycles with 2 in flight -> only 0x20 stream delivered; drop drains to 0.
- Wrap: RESET_PC=0xFFFFFFFE -> inst_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Mid-operation reset: reset=0 while FIFO holds 2 entries and 2 are in flight -> next cycle inst_valid=0, mem_req_valid=0, fetch_pc=RESET_PC. After release, fetching restarts at RESET_PC with no stale instructions.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Purpose: fetch-side PC owner; issues instruction-memory reads and queues tagged results for decode.
// Latency: response -> inst_valid next cycle; with 1-cycle memory, request handshake -> inst_valid two cycles later.
// Backpressure: requests gated by credit (in-flight + queued < QDEPTH), so responses are never stalled.
//
// Ports:
//   clock, reset         : clock; synchronous active-low reset
//   redirect_valid/_pc   : one-cycle branch redirect, flushes queued and in-flight fetches
//   mem_req_*            : read request (valid/ready), word address = fetch_pc
//   mem_rsp_*            : in-order read data, always accepted
//   inst_*               : queue head to decode (valid/ready), instruction and its address
//   fetch_pc             : next address to request
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] rsp_pc_q;
    logic [CW-1:0]     live_q;
    logic [CW-1:0]     drop_q;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [DATA_W-1:0] data_mem [QDEPTH];
    logic [ADDR_W-1:0] pc_mem   [QDEPTH];

    logic [CW+1:0] credit_used;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          pop;

    // Every outstanding or queued entry holds one slot; a request is only
    // issued when a slot is guaranteed for its response.
    assign credit_used   = {2'b00, live_q} + {2'b00, drop_q} + {2'b00, count_q};
    assign mem_req_valid = reset && !redirect_valid && (credit_used < (CW+2)'(QDEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign fetch_pc      = fetch_pc_q;

    assign req_fire = mem_req_valid && mem_req_ready;
    // Responses are in order, so all discarded data precedes any kept data.
    assign rsp_drop = mem_rsp_valid && (drop_q != '0);
    assign rsp_keep = mem_rsp_valid && (drop_q == '0);

    assign inst_valid = (count_q != '0);
    assign inst_data  = data_mem[rd_ptr_q];
    assign inst_pc    = pc_mem[rd_ptr_q];
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            rsp_pc_q   <= redirect_pc;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            // All in-flight reads become garbage; a response landing this
            // cycle retires the oldest of them immediately.
            drop_q     <= drop_q + live_q - CW'(mem_rsp_valid);
            live_q     <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            end
            if (rsp_drop) begin
                drop_q <= drop_q - CW'(1);
            end
            if (rsp_keep) begin
                data_mem[wr_ptr_q] <= mem_rsp_data;
                pc_mem[wr_ptr_q]   <= rsp_pc_q;
                wr_ptr_q           <= wr_ptr_q + PW'(1);
                rsp_pc_q           <= rsp_pc_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            live_q  <= live_q + CW'(req_fire) - CW'(rsp_keep);
            count_q <= count_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    // Protocol sanity: no unsolicited responses, occupancy never exceeds depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(mem_rsp_valid && live_q == '0 && drop_q == '0));
            assert (count_q <= CW'(QDEPTH));
        end
    end

endmodule
